// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer (head + skid).
// The head entry drives the MEM-side outputs. in_ready_o comes straight from a flop,
// so there is no combinational path from out_ready_i back to EX.
// Hazard compares against the head entry are combinational.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] alu_data_o,
  output logic [DATA_W-1:0] st_data_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic              fwd_a_o,
  output logic              fwd_b_o,
  output logic              load_use_o
);

  logic              head_valid_q, head_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] head_alu_q, skid_alu_q;
  logic [DATA_W-1:0] head_st_q, skid_st_q;
  logic [ADDR_W-1:0] head_rd_q, skid_rd_q;

  logic accept, consume;
  logic head_from_in, head_from_skid, skid_load;

  assign accept  = in_valid_i & in_ready_q;
  assign consume = head_valid_q & out_ready_i;

  // Head takes the new entry when empty or when it is drained the same cycle;
  // otherwise the new entry parks in the skid slot.
  assign head_from_in   = accept & (~head_valid_q | consume);
  assign head_from_skid = consume & ~accept & skid_valid_q;
  assign skid_load      = accept & head_valid_q & ~consume;

  // Next-state occupancy; flush wins over accept and consume.
  always_comb begin
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (accept && !consume) begin
      if (!head_valid_q) head_valid_d = 1'b1;
      else               skid_valid_d = 1'b1;
    end else if (consume && !accept) begin
      if (skid_valid_q) skid_valid_d = 1'b0;
      else              head_valid_d = 1'b0;
    end
  end

  // Occupancy and registered ready.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  // Head payload; stale data after a flush is harmless since ctrl_o is gated.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_ctrl_q <= '0;
      head_alu_q  <= '0;
      head_st_q   <= '0;
      head_rd_q   <= '0;
    end else if (head_from_in) begin
      head_ctrl_q <= ctrl_i;
      head_alu_q  <= alu_data_i;
      head_st_q   <= st_data_i;
      head_rd_q   <= rd_addr_i;
    end else if (head_from_skid) begin
      head_ctrl_q <= skid_ctrl_q;
      head_alu_q  <= skid_alu_q;
      head_st_q   <= skid_st_q;
      head_rd_q   <= skid_rd_q;
    end
  end

  // Skid payload, loaded only when the head is occupied and not draining.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      skid_ctrl_q <= '0;
      skid_alu_q  <= '0;
      skid_st_q   <= '0;
      skid_rd_q   <= '0;
    end else if (skid_load) begin
      skid_ctrl_q <= ctrl_i;
      skid_alu_q  <= alu_data_i;
      skid_st_q   <= st_data_i;
      skid_rd_q   <= rd_addr_i;
    end
  end

  // MEM-side outputs; ctrl is forced to a bubble when the head is empty.
  always_comb begin
    in_ready_o  = in_ready_q;
    out_valid_o = head_valid_q;
    ctrl_o      = head_valid_q ? head_ctrl_q : '0;
    alu_data_o  = head_alu_q;
    st_data_o   = head_st_q;
    rd_addr_o   = head_rd_q;
  end

  // Forwarding and load-use compares; register 0 never matches.
  always_comb begin
    logic rd_nz;
    rd_nz      = (head_rd_q != '0);
    fwd_a_o    = head_valid_q & head_ctrl_q[0] & rd_nz & (head_rd_q == rs_addr_i);
    fwd_b_o    = head_valid_q & head_ctrl_q[0] & rd_nz & (head_rd_q == rt_addr_i);
    load_use_o = head_valid_q & head_ctrl_q[3] & rd_nz &
                 ((head_rd_q == rs_addr_i) | (head_rd_q == rt_addr_i));
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed steps plus random traffic, checked against a
// queue model of a 2-deep in-order buffer.
module tb_ex_mem_pipe_reg;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] st;
    logic [4:0]  rd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ctrl_in = '0;
  logic [31:0] alu_in = '0;
  logic [31:0] st_in = '0;
  logic [4:0]  rd_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  ctrl_out;
  logic [31:0] alu_out;
  logic [31:0] st_out;
  logic [4:0]  rd_out;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic        fwd_a, fwd_b, load_use;

  int n_cmp = 0;
  int n_err = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.DATA_W(32), .ADDR_W(5), .CTRL_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .ctrl_i(ctrl_in), .alu_data_i(alu_in), .st_data_i(st_in), .rd_addr_i(rd_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ctrl_o(ctrl_out), .alu_data_o(alu_out), .st_data_o(st_out), .rd_addr_o(rd_out),
    .rs_addr_i(rs), .rt_addr_i(rt),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .load_use_o(load_use)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the buffer.
  task automatic check_model();
    logic v;
    ent_t h;
    logic ea, eb, el;
    v  = (q.size() > 0);
    h  = v ? q[0] : '0;
    ea = v && h.ctrl[0] && h.rd != 0 && h.rd == rs;
    eb = v && h.ctrl[0] && h.rd != 0 && h.rd == rt;
    el = v && h.ctrl[3] && h.rd != 0 && (h.rd == rs || h.rd == rt);
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("ctrl", 64'(ctrl_out), 64'(h.ctrl));
    if (v) begin
      chk("alu_data", 64'(alu_out), 64'(h.alu));
      chk("st_data", 64'(st_out), 64'(h.st));
      chk("rd_addr", 64'(rd_out), 64'(h.rd));
    end
    chk("fwd_a", 64'(fwd_a), 64'(ea));
    chk("fwd_b", 64'(fwd_b), 64'(eb));
    chk("load_use", 64'(load_use), 64'(el));
  endtask

  // One clock: decide handshakes from the model, advance it, then check 1 unit later.
  task automatic tick();
    bit acc, cons;
    ent_t e;
    acc = in_valid && (q.size() < 2);
    cons = out_ready && (q.size() > 0);
    e = '{ctrl: ctrl_in, alu: alu_in, st: st_in, rd: rd_in};
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    check_model();
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic [4:0] d);
    in_valid = v;
    ctrl_in  = c;
    alu_in   = a;
    st_in    = ~a;
    rd_in    = d;
  endtask

  initial begin
    // Reset held with an entry offered.
    drive(1'b1, 4'b0101, 32'h1234, 5'd3);
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ctrl", 64'(ctrl_out), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_alu", 64'(alu_out), 64'd0);
    chk("rst_rd", 64'(rd_out), 64'd0);
    chk("rst_fwd_a", 64'(fwd_a), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("first_accept", 64'(alu_out), 64'h1234);

    // Stream 1..8 with MEM always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'b0001, 32'(i), 5'(i));
      tick();
      chk("stream", 64'(alu_out), 64'(i));
    end
    drive(1'b0, '0, '0, '0);
    tick();

    // Backpressure: A then B held, then drained in order.
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 32'hAAAA, 5'd1);
    tick();
    drive(1'b1, 4'b0001, 32'hBBBB, 5'd2);
    tick();
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    drive(1'b0, '0, '0, '0);
    tick();
    chk("bp_hold_a", 64'(alu_out), 64'hAAAA);
    out_ready = 1'b1;
    tick();
    chk("bp_b_after_a", 64'(alu_out), 64'hBBBB);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with two held and a concurrent offer C.
    out_ready = 1'b0;
    drive(1'b1, 4'b0101, 32'h11, 5'd4);
    tick();
    drive(1'b1, 4'b0101, 32'h22, 5'd6);
    tick();
    flush = 1'b1;
    drive(1'b1, 4'b0101, 32'hCCCC, 5'd8);
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(ctrl_out), 64'd0);
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    tick();
    chk("flush_c_dropped", 64'(out_valid), 64'd0);

    // Hazards: load with RegWrite to r5, rs=5 rt=7.
    rs = 5'd5;
    rt = 5'd7;
    drive(1'b1, 4'b1001, 32'h50, 5'd5);
    tick();
    chk("hz_fwd_a", 64'(fwd_a), 64'd1);
    chk("hz_fwd_b", 64'(fwd_b), 64'd0);
    chk("hz_load_use", 64'(load_use), 64'd1);
    out_ready = 1'b1;
    drive(1'b1, 4'b1001, 32'h60, 5'd0);
    rs = 5'd0;
    rt = 5'd0;
    tick();
    chk("hz_r0_fwd_a", 64'(fwd_a), 64'd0);
    chk("hz_r0_fwd_b", 64'(fwd_b), 64'd0);
    chk("hz_r0_load_use", 64'(load_use), 64'd0);

    // RegWrite to r9, then consumed: bubble must not forward.
    drive(1'b1, 4'b0001, 32'h90, 5'd9);
    rs = 5'd9;
    tick();
    chk("bub_fwd_live", 64'(fwd_a), 64'd1);
    drive(1'b0, '0, '0, '0);
    tick();
    chk("bub_ctrl", 64'(ctrl_out), 64'd0);
    chk("bub_fwd_a", 64'(fwd_a), 64'd0);

    // Reset asserted mid-transfer drops entries immediately.
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 32'h77, 5'd7);
    tick();
    tick();
    rst = 1'b0;
    #1;
    q.delete();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 5'($urandom_range(0, 7)));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
